// File: rtl/uart_tx_data_port_if.sv
// Avalon-MM slave bus bundle for the UART transmit data port.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits, 1 clk latency)
interface uart_tx_data_port_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/uart_tx_data_port.sv
// CPU-to-UART transmit data port. The CPU pushes bytes into a DEPTH-entry FIFO;
// a small FSM pops them and hands each to the transmitter with a start/busy
// handshake. Sticky edge-capture bits (done, overflow) drive a masked interrupt.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port : byte presented to the transmitter, held until the next pop
//   tx_start : one-cycle start pulse to the transmitter
//   tx_busy  : transmitter busy, same clock domain
//   irq      : level interrupt, |(edge_capture & irq_mask) registered
module uart_tx_data_port #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   uart_tx_data_port_if.slave   bus,
   output logic [7:0]           out_port,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 irq
);

   typedef enum logic [1:0] {StIdle, StStart, StWaitAck, StWaitDone} state_t;

   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

   state_t      r_state, w_state_d;
   logic [7:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0] r_count;
   logic [7:0]  r_out_port;
   logic [1:0]  r_edge, r_mask;
   logic        r_irq;
   logic [31:0] r_readdata, w_rdata;

   logic w_wr, w_full, w_empty, w_push, w_pop, w_done_set, w_ovf_set, w_clr;

   assign w_wr      = bus.chipselect & ~bus.write_n;
   assign w_full    = (r_count == DepthCnt);
   assign w_empty   = (r_count == '0);
   // Full is judged before any same-cycle pop, so a push at full always drops.
   assign w_push    = w_wr & (bus.address == 2'd0) & ~w_full;
   assign w_ovf_set = w_wr & (bus.address == 2'd0) & w_full;
   assign w_clr     = w_wr & (bus.address == 2'd3);

   // Transmit FSM next-state and outputs.
   always_comb begin
      w_state_d  = r_state;
      w_pop      = 1'b0;
      w_done_set = 1'b0;
      tx_start   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!w_empty && !tx_busy) begin
               w_pop     = 1'b1;
               w_state_d = StStart;
            end
         end
         StStart: begin
            tx_start  = 1'b1;
            w_state_d = StWaitAck;
         end
         StWaitAck: begin
            if (tx_busy) w_state_d = StWaitDone;
         end
         StWaitDone: begin
            if (!tx_busy) begin
               w_done_set = 1'b1;
               w_state_d  = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= StIdle;
      else          r_state <= w_state_d;
   end

   // Storage needs no reset; emptiness is tracked by the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_out_port <= 8'h00;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_out_port <= r_mem[r_rd_ptr];
         end
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // A clear write wins over a same-cycle set; that set is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edge <= 2'b00;
         r_mask <= 2'b00;
         r_irq  <= 1'b0;
      end else begin
         if (w_clr) r_edge <= 2'b00;
         else       r_edge <= r_edge | {w_ovf_set, w_done_set};
         if (w_wr && (bus.address == 2'd2)) r_mask <= bus.writedata[1:0];
         r_irq <= |(r_edge & r_mask);
      end
   end

   always_comb begin
      w_rdata = 32'h0;
      unique case (bus.address)
         2'd0: w_rdata = {24'h0, r_out_port};
         2'd1: w_rdata = {16'h0, 8'(r_count), 4'h0, r_edge[1], w_full, w_empty,
                          (r_state != StIdle)};
         2'd2: w_rdata = {30'h0, r_mask};
         2'd3: w_rdata = {30'h0, r_edge};
         default: w_rdata = 32'h0;
      endcase
   end

   // Read data is registered every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_readdata <= 32'h0;
      else          r_readdata <= w_rdata;
   end

   assign bus.readdata = r_readdata;
   assign out_port     = r_out_port;
   assign irq          = r_irq;

endmodule

// File: tb/tb_uart_tx_data_port.sv
// Directed self-checking bench for uart_tx_data_port. Inputs are driven and
// outputs sampled 1 time unit after the rising clock edge.
module tb_uart_tx_data_port;

   logic       clk;
   logic       reset_n;
   logic [7:0] out_port;
   logic       tx_start;
   logic       tx_busy;
   logic       irq;

   int n_cmp;
   int n_err;
   int n_starts;

   uart_tx_data_port_if bus_if ();

   uart_tx_data_port #(
      .DEPTH (4),
      .AW    (2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus_if),
      .out_port (out_port),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_start === 1'b1) n_starts <= n_starts + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.address    = a;
      bus_if.writedata  = d;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      tick();
      d = bus_if.readdata;
      bus_if.chipselect = 1'b0;
   endtask

   // Transmitter model: wait (bounded) for tx_start, capture the byte, then
   // run a 3-cycle busy. Returns with busy just dropped, before the exit edge.
   task automatic tx_byte(output logic [7:0] b, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (tx_start === 1'b1) seen = 1'b1;
         else tick();
      end
      b = out_port;
      if (seen) begin
         tick();
         tx_busy = 1'b1;
         repeat (3) tick();
         tx_busy = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;
      logic        seen;
      int          snap;

      n_cmp    = 0;
      n_err    = 0;
      n_starts = 0;
      reset_n  = 1'b0;
      tx_busy  = 1'b0;
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;

      // Reset state
      repeat (2) tick();
      check_eq("rst_out_port", {24'h0, out_port}, 32'h0);
      check_eq("rst_tx_start", {31'h0, tx_start}, 32'h0);
      check_eq("rst_irq", {31'h0, irq}, 32'h0);
      check_eq("rst_readdata", bus_if.readdata, 32'h0);
      reset_n = 1'b1;
      tick();
      bus_read(2'd1, rd);
      check_eq("rst_status", rd, 32'h0000_0002);

      // Single byte: start pulse 2 clk after the write cycle
      bus_write(2'd0, 32'h0000_0041);
      check_eq("b1_no_early_start", {31'h0, tx_start}, 32'h0);
      tick();
      check_eq("b1_start", {31'h0, tx_start}, 32'h1);
      check_eq("b1_out_port", {24'h0, out_port}, 32'h41);
      tx_busy = 1'b1;
      tick();
      check_eq("b1_start_one_cycle", {31'h0, tx_start}, 32'h0);
      repeat (9) tick();
      tx_busy = 1'b0;
      tick();
      bus_read(2'd3, rd);
      check_eq("b1_edge_done", rd, 32'h1);
      check_eq("b1_start_count", n_starts, 32'd1);
      bus_write(2'd3, 32'h0);

      // Overflow with the FSM stalled by tx_busy
      tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h10 + i);
      tick();
      check_eq("ovf_no_pop", {24'h0, out_port}, 32'h41);
      bus_read(2'd1, rd);
      check_eq("ovf_status", rd, 32'h0000_040C);
      bus_read(2'd3, rd);
      check_eq("ovf_edge", rd, 32'h2);
      snap = n_starts;
      tx_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tx_byte(b, seen);
         check_eq("ovf_seq_seen", {31'h0, seen}, 32'h1);
         check_eq("ovf_seq_byte", {24'h0, b}, 32'h10 + i);
      end
      repeat (20) tick();
      check_eq("ovf_seq_count", n_starts - snap, 32'd4);
      bus_write(2'd3, 32'h0);
      bus_read(2'd1, rd);
      check_eq("ovf_drained", rd, 32'h0000_0002);

      // Masked done interrupt and clear
      bus_write(2'd2, 32'h1);
      bus_read(2'd2, rd);
      check_eq("mask_read", rd, 32'h1);
      bus_write(2'd0, 32'h55);
      tx_byte(b, seen);
      check_eq("irq_byte", {24'h0, b}, 32'h55);
      tick();
      check_eq("irq_lag", {31'h0, irq}, 32'h0);
      tick();
      check_eq("irq_set", {31'h0, irq}, 32'h1);
      bus_write(2'd3, 32'h0);
      check_eq("irq_hold_after_clr", {31'h0, irq}, 32'h1);
      tick();
      check_eq("irq_cleared", {31'h0, irq}, 32'h0);

      // Clear in the same cycle as the WAIT_DONE exit: the set is lost
      bus_write(2'd0, 32'h66);
      tx_byte(b, seen);
      check_eq("race_seen", {31'h0, seen}, 32'h1);
      bus_write(2'd3, 32'h0);
      bus_read(2'd3, rd);
      check_eq("race_edge", rd, 32'h0);
      tick();
      check_eq("race_irq", {31'h0, irq}, 32'h0);
      bus_read(2'd1, rd);
      check_eq("race_status", rd, 32'h0000_0002);

      // Reset during WAIT_DONE with two bytes queued
      bus_write(2'd0, 32'h77);
      bus_write(2'd0, 32'h78);
      bus_write(2'd0, 32'h79);
      tx_busy = 1'b1;
      bus_read(2'd1, rd);
      check_eq("mid_status", rd, 32'h0000_0201);
      check_eq("mid_out_port", {24'h0, out_port}, 32'h77);
      snap = n_starts;
      reset_n = 1'b0;
      #1;
      check_eq("arst_out_port", {24'h0, out_port}, 32'h0);
      check_eq("arst_tx_start", {31'h0, tx_start}, 32'h0);
      check_eq("arst_irq", {31'h0, irq}, 32'h0);
      check_eq("arst_readdata", bus_if.readdata, 32'h0);
      tx_busy = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      bus_read(2'd1, rd);
      check_eq("post_rst_status", rd, 32'h0000_0002);
      repeat (10) tick();
      check_eq("post_rst_no_start", n_starts - snap, 32'd0);
      bus_read(2'd2, rd);
      check_eq("post_rst_mask", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
